// File: rtl/serial_rx_fsm.sv
// Serial frame receiver: start bit (1), DATA_BITS data bits LSB first, stop bit (0), idle low.
// Good words go to a valid/ready holding register; framing and overrun errors pulse and are counted.
module serial_rx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [7:0]           err_count,
  output logic [2:0]           s
);

  localparam int H  = (BIT_CYCLES - 1) / 2;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 good, bad, load, drop, sample;

  // cnt counts down the clocks remaining until the next mid-bit sample.
  assign sample = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    good    = 1'b0;
    bad     = 1'b0;
    case (state)
      IDLE: begin
        if (rxd) begin
          if (H > 0) begin
            state_n = START;
            cnt_n   = CW'(H - 1);
          end else begin
            // With no half-bit offset the detection edge is also the start confirm.
            state_n = DATA;
            cnt_n   = CW'(BIT_CYCLES - 1);
            idx_n   = '0;
          end
        end
      end
      START: begin
        if (sample) begin
          if (rxd) begin
            state_n = DATA;
            cnt_n   = CW'(BIT_CYCLES - 1);
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (sample) begin
          shreg_n = {rxd, shreg[DATA_BITS-1:1]};
          cnt_n   = CW'(BIT_CYCLES - 1);
          if (idx == BW'(DATA_BITS - 1)) state_n = STOP;
          else                           idx_n   = idx + BW'(1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (sample) begin
          if (rxd) begin
            bad     = 1'b1;
            state_n = WAIT_LOW;
          end else begin
            good    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WAIT_LOW: begin
        if (!rxd) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A pending word may be replaced only when it is consumed on the same edge.
  assign load = good && (!valid || ready);
  assign drop = good && valid && !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      frame_err <= bad;
      overrun   <= drop;
      if (load) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if ((bad || drop) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign s = state;

endmodule

// File: tb/tb_serial_rx_fsm.sv
// Bench for serial_rx_fsm: one instance at one clock per bit, one at four clocks per bit.
// Delivered words are checked against an expected queue per instance.
module tb_serial_rx_fsm;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       rxd_a, rxd_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       frame_err_a, frame_err_b;
  logic       overrun_a, overrun_b;
  logic [7:0] err_count_a, err_count_b;
  logic [2:0] s_a, s_b;

  int tests = 0;
  int fails = 0;
  int err_exp_a = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  typedef struct {
    logic [7:0] word;
    logic       stop;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_rx_fsm #(.DATA_BITS(8), .BIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .rxd(rxd_a), .ready(ready_a), .data(data_a),
    .valid(valid_a), .frame_err(frame_err_a), .overrun(overrun_a),
    .err_count(err_count_a), .s(s_a)
  );

  serial_rx_fsm #(.DATA_BITS(8), .BIT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .rxd(rxd_b), .ready(ready_b), .data(data_b),
    .valid(valid_b), .frame_err(frame_err_b), .overrun(overrun_b),
    .err_count(err_count_b), .s(s_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rxd(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else          rxd_b = v;
  endtask

  // Drives start, data and stop; returns just after the stop-sample edge.
  task automatic send(input int sel, input logic [7:0] w, input logic stop, input logic stop_ready);
    int bc;
    int h;
    bc = (sel == 0) ? 1 : 4;
    h  = (bc - 1) / 2;
    set_rxd(sel, 1'b1);
    for (int k = 0; k < bc; k++) begin
      tick();
      if (k == 0 && sel == 0) check("s_after_start_a", s_a, 3'd2);
      if (k == 0 && sel == 1) check("s_after_start_b", s_b, 3'd1);
    end
    for (int i = 0; i < 8; i++) begin
      set_rxd(sel, w[i]);
      for (int k = 0; k < bc; k++) tick();
      if (sel == 0) check("s_data_a", s_a, (i == 7) ? 3'd3 : 3'd2);
    end
    set_rxd(sel, stop);
    if (sel == 0) ready_a = stop_ready;
    else          ready_b = stop_ready;
    for (int k = 0; k < h + 1; k++) tick();
  endtask

  always @(negedge clk) begin
    if (!rst_a && valid_a && ready_a) begin
      if (exp_q_a.size() == 0) check("unexpected_word_a", data_a, 32'hFFFF_FFFF);
      else check("word_a", data_a, exp_q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst_b && valid_b && ready_b) begin
      if (exp_q_b.size() == 0) check("unexpected_word_b", data_b, 32'hFFFF_FFFF);
      else check("word_b", data_b, exp_q_b.pop_front());
    end
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0};
    vecs[2] = '{8'hA5, 1'b1};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    for (int i = 5; i < 8; i++) vecs[i] = '{8'($urandom_range(0, 255)), 1'b0};

    rst_a = 1'b1; rst_b = 1'b1;
    rxd_a = 1'b0; rxd_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    tick(); tick();
    check("reset_s_a", s_a, 0);
    check("reset_valid_a", valid_a, 0);
    check("reset_data_a", data_a, 0);
    check("reset_err_a", err_count_a, 0);
    check("reset_s_b", s_b, 0);
    check("reset_valid_b", valid_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Table-driven frames at one clock per bit with ready held high.
    foreach (vecs[i]) begin
      send(0, vecs[i].word, vecs[i].stop, 1'b1);
      check("frame_err_a", frame_err_a, vecs[i].stop);
      check("overrun_a", overrun_a, 0);
      if (vecs[i].stop) begin
        err_exp_a++;
        check("valid_bad_a", valid_a, 0);
        check("s_wait_low_a", s_a, 3'd4);
        tick();
        check("frame_err_pulse_a", frame_err_a, 0);
        check("s_stuck_high_a", s_a, 3'd4);
        rxd_a = 1'b0;
        tick();
        check("s_back_idle_a", s_a, 3'd0);
      end else begin
        exp_q_a.push_back(vecs[i].word);
        check("valid_good_a", valid_a, 1);
        check("s_idle_a", s_a, 3'd0);
      end
      check("err_count_a", err_count_a, err_exp_a);
    end
    rxd_a = 1'b0;
    tick(); tick();

    // Overrun: second good frame while the first is still pending.
    ready_a = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0);
    exp_q_a.push_back(8'h11);
    check("ovr_first_valid", valid_a, 1);
    check("ovr_first_data", data_a, 8'h11);
    send(0, 8'h22, 1'b0, 1'b0);
    err_exp_a++;
    check("ovr_pulse", overrun_a, 1);
    check("ovr_data_kept", data_a, 8'h11);
    check("ovr_err_count", err_count_a, err_exp_a);
    rxd_a = 1'b0;
    tick();
    check("ovr_pulse_end", overrun_a, 0);
    ready_a = 1'b1;
    tick();
    check("ovr_valid_cleared", valid_a, 0);

    // Consume and load on the same stop edge.
    ready_a = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0);
    exp_q_a.push_back(8'h11);
    send(0, 8'h22, 1'b0, 1'b1);
    exp_q_a.push_back(8'h22);
    check("simul_data", data_a, 8'h22);
    check("simul_valid", valid_a, 1);
    check("simul_no_overrun", overrun_a, 0);
    check("simul_err_count", err_count_a, err_exp_a);
    rxd_a = 1'b0;
    tick(); tick();

    // Four clocks per bit: glitch rejection, full frame, reset mid-frame.
    rxd_b = 1'b1;
    tick();
    check("glitch_start_b", s_b, 3'd1);
    rxd_b = 1'b0;
    tick();
    check("glitch_idle_b", s_b, 3'd0);
    check("glitch_no_err_b", err_count_b, 0);
    tick(); tick();
    send(1, 8'h5A, 1'b0, 1'b1);
    exp_q_b.push_back(8'h5A);
    check("frame_valid_b", valid_b, 1);
    check("frame_data_b", data_b, 8'h5A);
    check("frame_err_b", frame_err_b, 0);
    rxd_b = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    ready_b = 1'b0;
    send(1, 8'hC3, 1'b0, 1'b0);
    check("held_valid_b", valid_b, 1);
    check("held_data_b", data_b, 8'hC3);
    rxd_b = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rxd_b = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rxd_b = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("mid_data_b", s_b, 3'd2);
    #2 rst_b = 1'b1;
    #1;
    check("rst_s_b", s_b, 3'd0);
    check("rst_valid_b", valid_b, 0);
    tick();
    rst_b = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    check("aborted_no_valid_b", valid_b, 0);
    check("aborted_no_err_b", err_count_b, 0);
    check("aborted_idle_b", s_b, 3'd0);

    // Error counter saturation.
    ready_a = 1'b1;
    for (int n = 0; n < 256; n++) begin
      send(0, 8'h00, 1'b1, 1'b1);
      rxd_a = 1'b0;
      tick();
      if (err_exp_a < 255) err_exp_a++;
    end
    check("err_count_saturated", err_count_a, err_exp_a);

    tick(); tick();
    check("queue_a_drained", exp_q_a.size(), 0);
    check("queue_b_drained", exp_q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_rx_fsm.md
Name: serial_rx_fsm

Overview:
- Receive-side partner of the team's serial transmit FSM.
- Samples the serial line `rxd` and recovers frames: one start bit (1), DATA_BITS data bits sent LSB first, one stop bit (0). The idle line level is 0.
- Delivers each good byte to the downstream consumer through a valid/ready holding register, and flags framing and overrun errors.
- Sits directly downstream of the transmitter's `txd` output. With BIT_CYCLES=1 it decodes the transmitter's one-bit-per-clock output directly.

Parameters:
- DATA_BITS, 8: data bits per frame.
- BIT_CYCLES, 1: clocks per bit period. Must be ≥1.
- H, (BIT_CYCLES-1)/2: derived local constant (integer division), the half-bit offset used for mid-bit sampling.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rxd  input  1  serial line, synchronous to clk.
- ready  input  1  consumer accepts `data` when ready && valid.
- data  output  DATA_BITS  last good received word. Held stable while valid=1.
- valid  output  1  `data` is pending.
- frame_err  output  1  one-cycle pulse when the stop bit is 1.
- overrun  output  1  one-cycle pulse when a good frame is dropped.
- err_count  output  8  saturating count of frame_err plus overrun events.
- s  output  3  current state code, for debug.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on `rst`.
- Reset values: state IDLE, s=0, data=0, valid=0, frame_err=0, overrun=0, err_count=0, all internal counters 0.
- Reset mid-frame aborts the frame. The partial word is discarded and no error is flagged.
- State codes: IDLE=0, START=1, DATA=2, STOP=3, WAIT_LOW=4. Unused codes go to IDLE.
- Sample timing: t0 is the first rising edge in IDLE at which rxd=1. All samples are taken at rising edges:
  - start confirm at t0+H;
  - data bit i at t0+H+BIT_CYCLES*(i+1);
  - stop bit at t0+H+BIT_CYCLES*(DATA_BITS+1).
- IDLE:
  - rxd=1 and H>0: go to START, with the cycle counter loaded for H-1 further clocks.
  - rxd=1 and H=0: the detection sample is the start confirm, so go straight to DATA with bit index 0.
- START: at the confirm sample, rxd=0 means a glitch; return to IDLE with no error. rxd=1 means go to DATA.
- DATA:
  - At each data sample, shift rxd into the shift register MSB-side, so the first bit lands at bit 0 after DATA_BITS shifts.
  - After bit DATA_BITS-1, go to STOP.
- STOP, at the stop sample:
  - rxd=0: good frame. Next state IDLE. A new start is accepted on the very next edge.
  - rxd=1: frame_err pulses for one cycle, the word is discarded, next state WAIT_LOW.
- WAIT_LOW: stay until rxd is sampled 0, then go to IDLE. This prevents a stuck-high line from retriggering.
- Output register, evaluated at the edge of a good stop sample:
  - If valid=0, or ready=1 in the same cycle: load data, valid=1 after that edge. Simultaneous consume and load means no overrun; valid stays 1 with the new word.
  - Otherwise (valid=1, ready=0): the new word is dropped, old data is kept, and overrun pulses for one cycle.
- Handshake: with no new load, ready && valid at an edge clears valid. data is never changed while valid=1 except via the simultaneous-load case above.
- err_count: increments by 1 on each frame_err or overrun pulse and saturates at 255. The two pulses can never coincide.
- Latency: valid rises at the edge of the stop sample, i.e. t0+H+BIT_CYCLES*(DATA_BITS+1).
- Counter widths: sized from the parameters, e.g. $clog2(BIT_CYCLES) for the cycle counter and $clog2(DATA_BITS) for the bit index. No wrap is permitted within a frame.

Test Plan:
- BIT_CYCLES=1, ready=1. rxd=1 at t0, then bits 1,0,1,0,0,1,0,1, then 0 → data=0xA5, valid high after edge t0+9. frame_err=0, err_count=0.
- Looped against the transmitter fsm (clk shared) with data=0x3C and a send pulse → receiver data=0x3C, valid asserted once, s passes through 0→2→3→0.
- Same frame as the first test but the stop bit is 1 → frame_err one-cycle pulse at t0+9, valid stays 0, err_count=1. State stays in WAIT_LOW until rxd=0, then IDLE.
- ready=0: two good frames 0x11 then 0x22 → data stays 0x11, overrun pulses at the second stop edge, err_count=1. Raising ready then clears valid.
- ready=1 at exactly the second stop edge while valid=1 → data=0x22, valid stays 1, no overrun.
- BIT_CYCLES=4 (H=1): a 1-clock rxd=1 glitch → back to IDLE, no error. A full frame of 0x5A with 4-clock bits → data=0x5A at t0+37. Asserting rst at mid-DATA → valid=0, s=0 immediately, and no output is produced for the aborted frame.
